// File: rtl/pc_unit_param_if.sv
// Fetch program-counter request/status bundle: control-side requests in,
// PC values and status out.
interface pc_unit_param_if #(
   parameter int WIDTH = 16
);
   logic             stall;
   logic             redir_valid;
   logic [1:0]       redir_mode;
   logic [WIDTH-1:0] redir_base;
   logic [WIDTH-1:0] redir_off;
   logic             exc_req;
   logic             rti_req;
   logic             halt_req;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] epc;
   logic             in_exc;
   logic             halted;
   logic             align_err;

   // Requests are level-sampled every clock; there is no ready back-pressure.
   modport master (
      output stall, redir_valid, redir_mode, redir_base, redir_off,
             exc_req, rti_req, halt_req,
      input  pc, pc_next, pc_plus, epc, in_exc, halted, align_err
   );

   modport slave (
      input  stall, redir_valid, redir_mode, redir_base, redir_off,
             exc_req, rti_req, halt_req,
      output pc, pc_next, pc_plus, epc, in_exc, halted, align_err
   );
endinterface

// File: rtl/pc_unit_param.sv
// Parametrised fetch PC with exception entry/return, sticky halt,
// prioritised redirect/stall and redirect alignment checking.
module pc_unit_param #(
   parameter int WIDTH     = 16,
   parameter int INC       = 2,
   parameter int RESET_VEC = 0,
   parameter int EXC_VEC   = 2
) (
   input  logic               clk,
   input  logic               rst,
   pc_unit_param_if.slave     bus,
   output logic [1:0]         state
);
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_EXC  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ALIGN_MASK = (INC > 1) ? WIDTH'(INC - 1) : '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             in_exc_q, in_exc_d;
   logic             align_q, align_d;
   logic             halt_d;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc_plus;

   assign pc_plus = pc_q + WIDTH'(INC);

   // Reserved mode 11 falls back to PC-relative.
   always_comb begin
      target = pc_q + bus.redir_off;
      case (bus.redir_mode)
         2'b01:   target = bus.redir_base + bus.redir_off;
         2'b10:   target = bus.redir_base;
         default: target = pc_q + bus.redir_off;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      epc_d    = epc_q;
      in_exc_d = in_exc_q;
      halt_d   = (state_q == ST_HALT);
      align_d  = 1'b0;
      if (state_q == ST_HALT) begin
         pc_d = pc_q;
      end else if (bus.exc_req && !in_exc_q) begin
         epc_d    = pc_plus;
         pc_d     = WIDTH'(EXC_VEC);
         in_exc_d = 1'b1;
      end else if (bus.rti_req && in_exc_q) begin
         pc_d     = epc_q;
         in_exc_d = 1'b0;
      end else if (bus.redir_valid) begin
         pc_d    = target & ~ALIGN_MASK;
         align_d = |(target & ALIGN_MASK);
      end else if (bus.halt_req) begin
         halt_d = 1'b1;
      end else if (!bus.stall) begin
         pc_d = pc_plus;
      end

      if (halt_d)        state_d = ST_HALT;
      else if (in_exc_d) state_d = ST_EXC;
      else               state_d = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= WIDTH'(RESET_VEC);
         epc_q    <= '0;
         in_exc_q <= 1'b0;
         align_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         epc_q    <= epc_d;
         in_exc_q <= in_exc_d;
         align_q  <= align_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_next   = pc_d;
   assign bus.pc_plus   = pc_plus;
   assign bus.epc       = epc_q;
   assign bus.in_exc    = in_exc_q;
   assign bus.halted    = (state_q == ST_HALT);
   assign bus.align_err = align_q;
   assign state         = state_q;
endmodule

// File: tb/tb_pc_unit_param.sv
// Bench for pc_unit_param: arithmetic reference model checked every cycle,
// plus directed scenarios with literal expected PC/status values.
module tb_pc_unit_param;
   localparam int W       = 16;
   localparam int INC     = 2;
   localparam int RST_V   = 0;
   localparam int EXC_V   = 2;
   localparam int MODV    = 1 << W;

   logic       clk;
   logic       rst;
   logic [1:0] state;
   int         n_tests;
   int         n_fail;

   pc_unit_param_if #(.WIDTH(W)) bus_if ();

   pc_unit_param #(
      .WIDTH(W), .INC(INC), .RESET_VEC(RST_V), .EXC_VEC(EXC_V)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus_if),
      .state (state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_pc, m_epc;
   bit m_in_exc, m_halted, m_align, m_valid;

   initial begin
      m_valid = 0; m_pc = 0; m_epc = 0;
      m_in_exc = 0; m_halted = 0; m_align = 0;
   end

   function automatic int m_target();
      int base, off;
      base = int'(bus_if.redir_base);
      off  = int'(bus_if.redir_off);
      case (bus_if.redir_mode)
         2'b01:   return (base + off) % MODV;
         2'b10:   return base;
         default: return (m_pc + off) % MODV;
      endcase
   endfunction

   function automatic int m_next_pc();
      int t;
      if (m_halted) return m_pc;
      if (bus_if.exc_req && !m_in_exc) return EXC_V;
      if (bus_if.rti_req && m_in_exc) return m_epc;
      if (bus_if.redir_valid) begin
         t = m_target();
         return t - (t % INC);
      end
      if (bus_if.halt_req || bus_if.stall) return m_pc;
      return (m_pc + INC) % MODV;
   endfunction

   always @(posedge clk) begin
      int npc;
      bit al;
      if (rst) begin
         m_pc = RST_V; m_epc = 0; m_in_exc = 0; m_halted = 0; m_align = 0;
         m_valid = 1;
      end else if (m_valid) begin
         npc = m_next_pc();
         al  = 0;
         if (!m_halted) begin
            if (bus_if.exc_req && !m_in_exc) begin
               m_epc    = (m_pc + INC) % MODV;
               m_in_exc = 1;
            end else if (bus_if.rti_req && m_in_exc) begin
               m_in_exc = 0;
            end else if (bus_if.redir_valid) begin
               al = (m_target() % INC) != 0;
            end else if (bus_if.halt_req) begin
               m_halted = 1;
            end
         end
         m_pc    = npc;
         m_align = al;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pc",        bus_if.pc,               W'(m_pc));
         chk("pc_plus",   bus_if.pc_plus,          W'((m_pc + INC) % MODV));
         chk("epc",       bus_if.epc,              W'(m_epc));
         chk("in_exc",    W'(bus_if.in_exc),       W'(m_in_exc));
         chk("halted",    W'(bus_if.halted),       W'(m_halted));
         chk("align_err", W'(bus_if.align_err),    W'(m_align));
         if (!rst) chk("pc_next", bus_if.pc_next, W'(m_next_pc()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus_if.stall       = 1'b0;
      bus_if.redir_valid = 1'b0;
      bus_if.redir_mode  = 2'b00;
      bus_if.redir_base  = '0;
      bus_if.redir_off   = '0;
      bus_if.exc_req     = 1'b0;
      bus_if.rti_req     = 1'b0;
      bus_if.halt_req    = 1'b0;
   endtask

   task automatic step(input logic s, input logic rv, input logic [1:0] m,
                       input logic [W-1:0] b, input logic [W-1:0] o,
                       input logic e, input logic r, input logic h);
      bus_if.stall       = s;
      bus_if.redir_valid = rv;
      bus_if.redir_mode  = m;
      bus_if.redir_base  = b;
      bus_if.redir_off   = o;
      bus_if.exc_req     = e;
      bus_if.rti_req     = r;
      bus_if.halt_req    = h;
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic idle();
      step(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      do_reset();
      chk("lit_reset_pc", bus_if.pc, 16'h0000);
      chk("lit_reset_epc", bus_if.epc, 16'h0000);
      repeat (4) idle();
      chk("lit_inc_pc", bus_if.pc, 16'h0008);

      repeat (2) step(1, 0, 2'b00, 16'h0, 16'h0, 0, 0, 0);
      chk("lit_stall_pc", bus_if.pc, 16'h0008);
      step(1, 1, 2'b00, 16'h0, 16'hFFFC, 0, 0, 0);
      chk("lit_redir_over_stall", bus_if.pc, 16'h0004);

      step(0, 1, 2'b01, 16'h0100, 16'h0011, 0, 0, 0);
      chk("lit_mode01_pc", bus_if.pc, 16'h0110);
      chk("lit_align_set", W'(bus_if.align_err), 16'h0001);
      idle();
      chk("lit_align_clear", W'(bus_if.align_err), 16'h0000);
      chk("lit_after_align_pc", bus_if.pc, 16'h0112);
      step(0, 1, 2'b11, 16'h5555, 16'h000E, 0, 0, 0);
      chk("lit_mode11_pc", bus_if.pc, 16'h0120);
      step(0, 1, 2'b10, 16'hFFFE, 16'h0, 0, 0, 0);
      chk("lit_mode10_pc", bus_if.pc, 16'hFFFE);
      idle();
      chk("lit_wrap_pc", bus_if.pc, 16'h0000);

      step(0, 1, 2'b10, 16'h0020, 16'h0, 0, 0, 0);
      step(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 0);
      chk("lit_exc_pc", bus_if.pc, 16'h0002);
      chk("lit_exc_epc", bus_if.epc, 16'h0022);
      step(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 0);
      chk("lit_nested_epc", bus_if.epc, 16'h0022);
      chk("lit_nested_pc", bus_if.pc, 16'h0004);
      step(0, 0, 2'b00, 16'h0, 16'h0, 0, 1, 0);
      chk("lit_rti_pc", bus_if.pc, 16'h0022);
      chk("lit_rti_in_exc", W'(bus_if.in_exc), 16'h0000);
      step(0, 0, 2'b00, 16'h0, 16'h0, 0, 1, 0);
      chk("lit_rti_ignored_pc", bus_if.pc, 16'h0024);

      step(1, 1, 2'b00, 16'h0, 16'h0100, 1, 1, 0);
      chk("lit_exc_wins_pc", bus_if.pc, 16'h0002);
      chk("lit_exc_wins_epc", bus_if.epc, 16'h0026);
      step(0, 0, 2'b00, 16'h0, 16'h0, 0, 1, 0);
      chk("lit_rti2_pc", bus_if.pc, 16'h0026);
      step(0, 1, 2'b10, 16'h0040, 16'h0, 0, 0, 1);
      chk("lit_halt_dropped_pc", bus_if.pc, 16'h0040);
      chk("lit_halt_dropped", W'(bus_if.halted), 16'h0000);

      step(0, 1, 2'b10, 16'h0030, 16'h0, 0, 0, 0);
      step(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 1);
      chk("lit_halted", W'(bus_if.halted), 16'h0001);
      for (int i = 0; i < 5; i++) begin
         step(i[0], ~i[0], 2'b10, 16'h1234, 16'h0, ~i[0], i[0], 0);
         chk("lit_halt_hold_pc", bus_if.pc, 16'h0030);
      end
      do_reset();
      chk("lit_rst_halt_pc", bus_if.pc, 16'h0000);
      chk("lit_rst_halt_flag", W'(bus_if.halted), 16'h0000);

      repeat (2) idle();
      step(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 0);
      chk("lit_exc2_epc", bus_if.epc, 16'h0006);
      do_reset();
      chk("lit_rst_exc_in_exc", W'(bus_if.in_exc), 16'h0000);
      chk("lit_rst_exc_epc", bus_if.epc, 16'h0000);
      idle();
      chk("lit_post_rst_pc", bus_if.pc, 16'h0002);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_unit_param.md
Name: pc_unit_param

Overview:
- Parametrised fetch program-counter unit. Successor to the fixed 16-bit PC block.
- Generalises address width, increment and vectors. Adds exception-return (EPC and RTI), a sticky halt state, explicit stall/redirect priority, a redirect addressing mode, and alignment checking.
- Sits at the front of fetch. Drives the instruction-memory address. Receives redirects from decode/execute and exception requests from the control logic.

Parameters:
- WIDTH, 16, address/data width in bits.
- INC, 2, sequential increment in bytes.
- RESET_VEC, 0, PC value after reset.
- EXC_VEC, 2, exception-handler entry address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold PC (fetch stall).
- redir_valid  in  1  redirect request this cycle.
- redir_mode  in  2  00 = PC+off, 01 = base+off, 10 = base, 11 = reserved (treated as 00).
- redir_base  in  WIDTH  register base for modes 01/10.
- redir_off  in  WIDTH  signed offset, two's complement.
- exc_req  in  1  exception request (SIIC).
- rti_req  in  1  return from exception.
- halt_req  in  1  enter halt.
- pc  out  WIDTH  current PC (registered).
- pc_next  out  WIDTH  combinational next-PC value.
- pc_plus  out  WIDTH  pc+INC, combinational, used as the link value.
- epc  out  WIDTH  saved exception return address (registered).
- in_exc  out  1  handler active (registered).
- halted  out  1  halt state (registered).
- align_err  out  1  one-cycle pulse: last accepted redirect target was misaligned.

Behaviour:
- Reset: a single clk edge with rst=1 sets pc=RESET_VEC, epc=0, in_exc=0, halted=0, align_err=0. Reset overrides every other input, including when it arrives mid-exception or while halted.
- Arithmetic is modulo 2^WIDTH; carry out is discarded. Wrap-around is legal, e.g. pc=FFFE with INC=2 gives 0000.
- States are RUN, EXC (RUN with in_exc=1) and HALT.
- Next-PC priority, highest first:
  1. halted=1: pc holds; all inputs except rst are ignored.
  2. exc_req and in_exc=0: epc<=pc_plus, pc<=EXC_VEC, in_exc<=1.
  3. rti_req and in_exc=1: pc<=epc, in_exc<=0.
  4. redir_valid: pc<=target.
  5. halt_req: halted<=1, pc holds.
  6. stall: pc holds.
  7. Otherwise: pc<=pc_plus.
- Priority consequences:
  - Redirect and exception both override stall.
  - halt_req together with a redirect: the redirect is taken and halt_req is dropped; control must re-assert it.
- exc_req while in_exc=1 (nested exception): ignored. epc is not overwritten and the lower-priority rules apply.
- rti_req while in_exc=0: ignored; the lower-priority rules apply.
- Redirect target:
  - Mode 00: pc+redir_off. Mode 01: redir_base+redir_off. Mode 10: redir_base.
  - If INC>1 and target mod INC != 0: the low log2(INC) bits are cleared before loading, and align_err=1 in the following cycle only.
  - align_err is 0 in every other cycle.
- Latency: the effect of every request is visible on pc one clock after the request is sampled. pc_next always equals the value pc will take at the next edge when rst=0.
- pc_plus is valid every cycle, including during stall and halt.

Test Plan:
- Reset and increment: rst for 1 cycle, then 4 idle cycles -> pc = 0000, 0002, 0004, 0006, 0008; epc=0, in_exc=0, halted=0.
- Stall vs redirect: at pc=0008 assert stall for 2 cycles -> pc stays 0008. Then assert stall with redir_valid, mode 00, off=FFFC -> pc=0004 next cycle.
- Redirect modes and alignment: mode 01, base=0100, off=0011 -> pc=0110 with align_err=1 for exactly one cycle. Mode 10, base=FFFE, then idle -> pc=FFFE, then 0000 (wrap).
- Exception/RTI: at pc=0020 assert exc_req -> pc=0002, epc=0022, in_exc=1. A second exc_req while in handler -> epc stays 0022. rti_req -> pc=0022, in_exc=0. A further rti_req -> plain increment to 0024.
- Simultaneous events: exc_req together with redir_valid, rti_req and stall -> exception taken, pc=EXC_VEC. halt_req together with redir_valid -> redirect taken, halted stays 0.
- Halt and reset: halt_req at pc=0030 -> halted=1, pc=0030 held for 5 cycles while exc_req and redir_valid toggle. rst -> pc=0000, halted=0.
